// File: rtl/nested_loop_counter_if.sv
// Job bus for nested_loop_counter: config and start/stall in, beat stream out.
// master = job issuer / consumer, slave = the counter itself.
interface nested_loop_counter_if #(
  parameter int MAX_COLS  = 32,
  parameter int MAX_ROWS  = 32,
  parameter int MAX_TILES = 8,
  parameter int ADDR_W    = 16
);
  localparam int CW1 = $clog2(MAX_COLS + 1);
  localparam int RW1 = $clog2(MAX_ROWS + 1);
  localparam int TW1 = $clog2(MAX_TILES + 1);
  localparam int CW  = (MAX_COLS  > 1) ? $clog2(MAX_COLS)  : 1;
  localparam int RW  = (MAX_ROWS  > 1) ? $clog2(MAX_ROWS)  : 1;
  localparam int TW  = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

  logic              start;
  logic              stall;
  logic [CW1-1:0]    cfg_cols;
  logic [RW1-1:0]    cfg_rows;
  logic [TW1-1:0]    cfg_tiles;
  logic [ADDR_W-1:0] cfg_base;
  logic [CW-1:0]     col_cntr;
  logic [RW-1:0]     row_cntr;
  logic [TW-1:0]     tile_cntr;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic              last_col;
  logic              last_row;
  logic              busy;
  logic              done;

  modport master (
    output start, stall, cfg_cols, cfg_rows, cfg_tiles, cfg_base,
    input  col_cntr, row_cntr, tile_cntr, addr, valid, last_col, last_row, busy, done
  );

  modport slave (
    input  start, stall, cfg_cols, cfg_rows, cfg_tiles, cfg_base,
    output col_cntr, row_cntr, tile_cntr, addr, valid, last_col, last_row, busy, done
  );
endinterface

// File: rtl/nested_loop_counter.sv
// Three-level (col/row/tile) loop counter with linear address for MM tiling.
// Bounds are latched and clamped at start; stall freezes the whole beat.
module nested_loop_counter #(
  parameter int MAX_COLS  = 32,
  parameter int MAX_ROWS  = 32,
  parameter int MAX_TILES = 8,
  parameter int ADDR_W    = 16
) (
  input logic                 clk,
  input logic                 rst,
  nested_loop_counter_if.slave io
);
  localparam int CW1 = $clog2(MAX_COLS + 1);
  localparam int RW1 = $clog2(MAX_ROWS + 1);
  localparam int TW1 = $clog2(MAX_TILES + 1);
  localparam int CW  = (MAX_COLS  > 1) ? $clog2(MAX_COLS)  : 1;
  localparam int RW  = (MAX_ROWS  > 1) ? $clog2(MAX_ROWS)  : 1;
  localparam int TW  = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e            state_q, state_d;
  logic [CW1-1:0]    cols_q, cols_d;
  logic [RW1-1:0]    rows_q, rows_d;
  logic [TW1-1:0]    tiles_q, tiles_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [TW-1:0]     tile_q, tile_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;

  logic [CW-1:0] col_max;
  logic [RW-1:0] row_max;
  logic [TW-1:0] tile_max;
  logic          beat, col_end, row_end, tile_end, cfg_zero;

  // Clamped bounds never exceed MAX, so bound-1 always fits the counter width.
  assign col_max  = CW'(cols_q - CW1'(1));
  assign row_max  = RW'(rows_q - RW1'(1));
  assign tile_max = TW'(tiles_q - TW1'(1));

  assign beat     = (state_q == RUN) && !io.stall;
  assign col_end  = (col_q == col_max);
  assign row_end  = (row_q == row_max);
  assign tile_end = (tile_q == tile_max);
  assign cfg_zero = (io.cfg_cols == '0) || (io.cfg_rows == '0) || (io.cfg_tiles == '0);

  always_comb begin
    state_d = state_q;
    cols_d  = cols_q;
    rows_d  = rows_q;
    tiles_d = tiles_q;
    col_d   = col_q;
    row_d   = row_q;
    tile_d  = tile_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    unique case (state_q)
      // The done cycle is still the tail of the previous job: start is ignored there.
      IDLE: if (io.start && !done_q) begin
        if (cfg_zero) begin
          state_d = FIN;
        end else begin
          cols_d  = (io.cfg_cols  > CW1'(MAX_COLS))  ? CW1'(MAX_COLS)  : io.cfg_cols;
          rows_d  = (io.cfg_rows  > RW1'(MAX_ROWS))  ? RW1'(MAX_ROWS)  : io.cfg_rows;
          tiles_d = (io.cfg_tiles > TW1'(MAX_TILES)) ? TW1'(MAX_TILES) : io.cfg_tiles;
          col_d   = '0;
          row_d   = '0;
          tile_d  = '0;
          addr_d  = io.cfg_base;
          state_d = RUN;
        end
      end
      RUN: if (beat) begin
        addr_d = addr_q + ADDR_W'(1);
        if (!col_end) begin
          col_d = col_q + CW'(1);
        end else begin
          col_d = '0;
          if (!row_end) begin
            row_d = row_q + RW'(1);
          end else begin
            row_d = '0;
            if (!tile_end) begin
              tile_d = tile_q + TW'(1);
            end else begin
              tile_d  = '0;
              addr_d  = addr_q;
              state_d = FIN;
            end
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cols_q  <= '0;
      rows_q  <= '0;
      tiles_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      tile_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cols_q  <= cols_d;
      rows_q  <= rows_d;
      tiles_q <= tiles_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tile_q  <= tile_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign io.col_cntr  = col_q;
  assign io.row_cntr  = row_q;
  assign io.tile_cntr = tile_q;
  assign io.addr      = addr_q;
  assign io.valid     = beat;
  assign io.last_col  = beat && col_end;
  assign io.last_row  = beat && col_end && row_end;
  assign io.busy      = (state_q != IDLE);
  assign io.done      = done_q;
endmodule

// File: tb/tb_nested_loop_counter.sv
// Randomized bench for nested_loop_counter: each job's beat list is expanded
// from the nested-loop definition and consumed as the DUT issues beats.
module tb_nested_loop_counter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nested_loop_counter_if #(.MAX_COLS(32), .MAX_ROWS(32), .MAX_TILES(8), .ADDR_W(16)) bus ();

  nested_loop_counter #(.MAX_COLS(32), .MAX_ROWS(32), .MAX_TILES(8), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    int          col;
    int          row;
    int          tile;
    logic [15:0] addr;
    bit          lc;
    bit          lr;
  } beat_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_col"},   bus.col_cntr,  0);
    chk({tag, "_row"},   bus.row_cntr,  0);
    chk({tag, "_tile"},  bus.tile_cntr, 0);
    chk({tag, "_addr"},  bus.addr,      0);
    chk({tag, "_valid"}, bus.valid,     0);
    chk({tag, "_lc"},    bus.last_col,  0);
    chk({tag, "_lr"},    bus.last_row,  0);
    chk({tag, "_busy"},  bus.busy,      0);
    chk({tag, "_done"},  bus.done,      0);
  endtask

  // One job from start to the cycle after done. stall_at/stall_len force a
  // stall burst when beat index stall_at is next; noise toggles start/cfg mid-job.
  task automatic run_job(input int c, input int r, input int t, input logic [15:0] base,
                         input int stall_pct, input int stall_at, input int stall_len,
                         input bit noise);
    beat_t q[$];
    beat_t b;
    int ec, er, et, idx, issued, burst, n;
    logic [15:0] last_addr;
    ec = clampi(c, 32);
    er = clampi(r, 32);
    et = clampi(t, 8);
    idx = 0;
    last_addr = base;
    if (c > 0 && r > 0 && t > 0) begin
      for (int ti = 0; ti < et; ti++)
        for (int ri = 0; ri < er; ri++)
          for (int ci = 0; ci < ec; ci++) begin
            b.col  = ci;
            b.row  = ri;
            b.tile = ti;
            b.addr = base + 16'(idx);
            b.lc   = (ci == ec - 1);
            b.lr   = (ci == ec - 1) && (ri == er - 1);
            q.push_back(b);
            last_addr = b.addr;
            idx++;
          end
    end

    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.cfg_cols  = 6'(c);
    bus.cfg_rows  = 6'(r);
    bus.cfg_tiles = 4'(t);
    bus.cfg_base  = base;
    bus.stall     = 1'($urandom_range(1, 0));
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_valid", bus.valid, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    issued = 0;
    burst  = 0;
    n      = 1;
    while (q.size() > 0 && n < 20000) begin
      if (issued == stall_at && burst < stall_len) begin
        bus.stall = 1'b1;
        burst++;
      end else begin
        bus.stall = ($urandom_range(99, 0) < stall_pct);
      end
      if (noise) begin
        bus.start     = 1'($urandom_range(1, 0));
        bus.cfg_cols  = 6'($urandom_range(63, 0));
        bus.cfg_rows  = 6'($urandom_range(63, 0));
        bus.cfg_tiles = 4'($urandom_range(15, 0));
        bus.cfg_base  = 16'($urandom);
      end
      #1;
      b = q[0];
      chk("run_busy",  bus.busy, 1);
      chk("run_done",  bus.done, 0);
      chk("run_valid", bus.valid, !bus.stall);
      chk("col",  bus.col_cntr,  b.col);
      chk("row",  bus.row_cntr,  b.row);
      chk("tile", bus.tile_cntr, b.tile);
      chk("addr", bus.addr,      b.addr);
      chk("last_col", bus.last_col, b.lc && !bus.stall);
      chk("last_row", bus.last_row, b.lr && !bus.stall);
      if (!bus.stall) begin
        void'(q.pop_front());
        issued++;
      end
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0) chk("beat_timeout", q.size(), 0);

    bus.stall = 1'($urandom_range(1, 0));
    bus.start = noise;
    #1;
    chk("fin_busy",  bus.busy, 1);
    chk("fin_valid", bus.valid, 0);
    chk("fin_done",  bus.done, 0);
    if (idx > 0) begin
      chk("fin_col",  bus.col_cntr,  0);
      chk("fin_row",  bus.row_cntr,  0);
      chk("fin_tile", bus.tile_cntr, 0);
      chk("fin_addr", bus.addr,      last_addr);
    end
    @(posedge clk); #1;
    bus.start = noise;
    #1;
    chk("done_pulse", bus.done, 1);
    chk("done_busy",  bus.busy, 0);
    chk("done_valid", bus.valid, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    #1;
    chk("post_done", bus.done, 0);
    chk("post_busy", bus.busy, 0);
  endtask

  task automatic reset_mid_job();
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.stall     = 1'b0;
    bus.cfg_cols  = 6'd4;
    bus.cfg_rows  = 6'd2;
    bus.cfg_tiles = 4'd2;
    bus.cfg_base  = 16'h0100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_valid", bus.valid, 1);
    chk("pre_rst_addr",  bus.addr,  16'h0106);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("no_done_after_rst", bus.done, 0);
      chk("idle_after_rst",    bus.busy, 0);
    end
  endtask

  initial begin
    int c, r, t, z;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    bus.cfg_cols  = '0;
    bus.cfg_rows  = '0;
    bus.cfg_tiles = '0;
    bus.cfg_base  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    run_job(4, 2, 2, 16'h0100, 0, -1, 0, 1'b0);
    run_job(4, 2, 2, 16'h0100, 0, 5, 3, 1'b0);
    run_job(0, 2, 2, 16'h0200, 0, -1, 0, 1'b0);
    run_job(40, 1, 1, 16'h0300, 0, -1, 0, 1'b0);
    reset_mid_job();
    run_job(4, 2, 2, 16'h0100, 0, -1, 0, 1'b0);
    run_job(2, 2, 1, 16'hFFFE, 0, -1, 0, 1'b1);

    for (int j = 0; j < 24; j++) begin
      c = $urandom_range(40, 1);
      r = $urandom_range(5, 1);
      t = $urandom_range(3, 1);
      if ($urandom_range(9, 0) == 0) begin
        z = $urandom_range(2, 0);
        if (z == 0) c = 0;
        else if (z == 1) r = 0;
        else t = 0;
      end
      run_job(c, r, t, 16'($urandom), $urandom_range(40, 0),
              $urandom_range(20, 0), $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nested_loop_counter.md
Name: nested_loop_counter

Overview:
- Runtime-configurable three-level loop counter and linear address generator for matrix-multiply tiling.
- It is the parametrised successor to the fixed pixel/slice counter: column, row and tile levels, each bounded at runtime up to a compile-time maximum.
- It adds a start/done handshake, a stall input and last-beat flags.
- It drives the read-address and control sequencing of the MM datapath.

Parameters:
MAX_COLS, 32, maximum columns per row (innermost level)
MAX_ROWS, 32, maximum rows per tile (middle level)
MAX_TILES, 8, maximum tiles per job (outer level)
ADDR_W, 16, width of the linear address output

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  job start request; sampled only in IDLE
stall  in  1  hold all counters and the address this cycle; suppresses valid
cfg_cols  in  CW1=clog2(MAX_COLS+1)  column count for the job, 0..MAX_COLS
cfg_rows  in  RW1=clog2(MAX_ROWS+1)  row count for the job
cfg_tiles  in  TW1=clog2(MAX_TILES+1)  tile count for the job
cfg_base  in  ADDR_W  starting address
col_cntr  out  CW=max(clog2(MAX_COLS),1)  current column index
row_cntr  out  RW=max(clog2(MAX_ROWS),1)  current row index
tile_cntr  out  TW=max(clog2(MAX_TILES),1)  current tile index
addr  out  ADDR_W  linear address of the current beat
valid  out  1  current beat (counters/addr) is issued
last_col  out  1  valid beat is the final column of its row
last_row  out  1  valid beat is the final beat of its tile (last column of last row)
busy  out  1  FSM is not in IDLE
done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset: FSM=IDLE; all counters, addr, valid, last_col, last_row, busy and done are 0. Latched config is cleared.
- Reset mid-job aborts immediately. No done pulse is issued for the aborted job.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1 with all cfg_* nonzero:
  - Latch the config. cfg values above their MAX are clamped to the MAX.
  - Clear the counters, set addr=cfg_base, go to RUN.
  - The first valid is asserted the cycle after start.
- IDLE, start=1 with any cfg_* equal to 0: go to FIN with no beats issued; done pulses one cycle later.
- RUN:
  - valid = !stall. On a valid beat the counters advance with col innermost.
  - col wraps to 0 at cols-1 and increments row. row wraps at rows-1 and increments tile.
  - addr increments by 1 on every valid beat. Wrap at 2^ADDR_W is modulo, with no flag.
  - With stall=1, all state holds and valid=0. Stall has no effect outside RUN.
- Final beat (col=cols-1, row=rows-1, tile=tiles-1) accepted: go to FIN. Counters return to 0 and addr holds.
- FIN: done=1 for exactly one cycle, then IDLE. busy=1 in RUN and FIN.
- last_col and last_row are combinational from the counters and the latched bounds, gated by valid.
- start while busy is ignored. cfg changes while busy are ignored, because the latched copy is used.
- start in the same cycle as done (FIN) is ignored. A new job needs start in IDLE.
- Total beats per job = cols*rows*tiles. Cycles from start to done = beats + stall cycles + 2.
- Counter comparisons use the latched bounds minus 1 at counter width. No width overflow is possible because the bounds are clamped.

Test Plan:
- cols=4, rows=2, tiles=2, base=0x100, no stall -> 16 valid beats with addr 0x100..0x10F.
  - last_col on beats 3, 7, 11, 15 (0-based) and last_row on beats 7 and 15.
  - done pulses once at cycle 18 after start; busy is low after done.
- Same job with stall high on beats 5..7 -> valid low for 3 cycles with counters and addr frozen.
  - Beat sequence is unchanged; done is delayed by exactly 3 cycles.
- cfg_cols=0, start -> no valid, done one cycle after FIN entry, busy high for exactly 1 cycle.
- cfg_cols=40 with MAX_COLS=32, rows=1, tiles=1 -> 32 beats and col_cntr wraps 31->0.
- Job in progress, rst asserted at beat 6 -> next cycle all outputs 0, FSM in IDLE, no done.
  - A subsequent start runs a full job correctly.
- start pulsed and cfg changed mid-job; base=0xFFFE, 4 beats -> ignored start/cfg have no effect.
  - addr sequence is 0xFFFE, 0xFFFF, 0x0000, 0x0001.
